// File: rtl/sram_word_ctrl_pkg.sv
// rtl/sram_word_ctrl_pkg.sv - shared types and constants for the word-to-half-word SRAM controller
package sram_word_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LO_SETUP,
    LO_ACC,
    HI_SETUP,
    HI_ACC,
    DONE
  } state_t;

  localparam logic HALF_LO    = 1'b0;
  localparam logic HALF_HI    = 1'b1;
  localparam int   WAIT_CNT_W = 4;

  typedef struct packed {
    logic ce_n;
    logic oe_n;
    logic we_n;
    logic lb_n;
    logic ub_n;
    logic io_oe;
  } strobe_t;

  localparam strobe_t STROBE_IDLE = '{ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1,
                                      lb_n: 1'b1, ub_n: 1'b1, io_oe: 1'b0};

  // Strobes for the SETUP cycle of a half; write strobe is asserted later in ACC.
  function automatic strobe_t setup_strobes(input logic wr, input logic [1:0] be);
    strobe_t s;
    s.ce_n  = 1'b0;
    s.oe_n  = wr;
    s.we_n  = 1'b1;
    s.lb_n  = wr ? ~be[0] : 1'b0;
    s.ub_n  = wr ? ~be[1] : 1'b0;
    s.io_oe = wr;
    return s;
  endfunction

endpackage

// File: rtl/sram_wait_cnt.sv
// rtl/sram_wait_cnt.sv - loadable down-counter timing the strobe-active ACC phases
module sram_wait_cnt
  import sram_word_ctrl_pkg::*;
#(
  parameter int W = WAIT_CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/sram_word_ctrl.sv
// rtl/sram_word_ctrl.sv - 32-bit CPU word bus to 16-bit async SRAM, two half-word accesses per word
// Optional SRAM_BYTE_LANE_EN adds mem_be write byte enables and skips fully-disabled halves.
module sram_word_ctrl
  import sram_word_ctrl_pkg::*;
#(
  parameter int SRAM_AW     = 18,
  parameter int WAIT_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_re,
  input  logic               mem_we,
  input  logic [29:0]        memaddr,
  input  logic [31:0]        memdata_in,
`ifdef SRAM_BYTE_LANE_EN
  input  logic [3:0]         mem_be,
`endif
  output logic [31:0]        memdata_out,
  output logic               mem_ready,
  output logic [SRAM_AW-1:0] sram_a,
  output logic [15:0]        sram_io_out,
  input  logic [15:0]        sram_io_in,
  output logic               sram_io_oe,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n,
  output logic               sram_lb_n,
  output logic               sram_ub_n
);

  state_t             state_q, state_d;
  logic [SRAM_AW-2:0] addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [31:0]        memdata_out_q, memdata_out_d;
  logic               wr_q, wr_d;
  logic [1:0]         be_hi_q, be_hi_d;
  logic               mem_ready_q, mem_ready_d;
  logic [SRAM_AW-1:0] sram_a_q, sram_a_d;
  logic [15:0]        io_out_q, io_out_d;
  strobe_t            strobe_q, strobe_d;

  logic       cnt_load, cnt_done;
  logic       go_lo, go_hi, go_done;
  logic [3:0] be_req, be_cur;
  logic [1:0] lane_be;
  logic       unused_addr_bits;

`ifdef SRAM_BYTE_LANE_EN
  assign be_req = mem_be;
`else
  assign be_req = 4'hF;
`endif

  // Upper word-address bits alias onto the same SRAM words.
  assign unused_addr_bits = ^memaddr[29:SRAM_AW-1];

  sram_wait_cnt #(.W(WAIT_CNT_W)) u_wait_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (WAIT_CNT_W'(WAIT_CYCLES - 1)),
    .done     (cnt_done)
  );

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rdata_d       = rdata_q;
    memdata_out_d = memdata_out_q;
    wr_d          = wr_q;
    be_hi_d       = be_hi_q;
    mem_ready_d   = 1'b0;
    sram_a_d      = sram_a_q;
    io_out_d      = io_out_q;
    strobe_d      = strobe_q;
    cnt_load      = 1'b0;
    go_lo         = 1'b0;
    go_hi         = 1'b0;
    go_done       = 1'b0;
    be_cur        = 4'hF;
    lane_be       = 2'b11;

    case (state_q)
      IDLE: begin
        if (mem_re || mem_we) begin
          addr_d  = memaddr[SRAM_AW-2:0];
          wdata_d = memdata_in;
          wr_d    = mem_we;
          be_cur  = mem_we ? be_req : 4'hF;
          be_hi_d = be_cur[3:2];
          if (|be_cur[1:0]) begin
            go_lo   = 1'b1;
            lane_be = be_cur[1:0];
          end else if (|be_cur[3:2]) begin
            go_hi   = 1'b1;
            lane_be = be_cur[3:2];
          end else begin
            go_done = 1'b1;
          end
        end
      end
      LO_SETUP, HI_SETUP: begin
        state_d       = (state_q == LO_SETUP) ? LO_ACC : HI_ACC;
        cnt_load      = 1'b1;
        strobe_d.we_n = ~wr_q;
      end
      LO_ACC: begin
        if (cnt_done) begin
          if (!wr_q) rdata_d[15:0] = sram_io_in;
          if (|be_hi_q) begin
            go_hi   = 1'b1;
            lane_be = be_hi_q;
          end else begin
            go_done = 1'b1;
          end
        end
      end
      HI_ACC: begin
        if (cnt_done) begin
          if (!wr_q) rdata_d[31:16] = sram_io_in;
          go_done = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d  = IDLE;
        strobe_d = STROBE_IDLE;
      end
    endcase

    // Address and write data only change here, with sram_we_n high.
    if (go_lo || go_hi) begin
      state_d  = go_hi ? HI_SETUP : LO_SETUP;
      sram_a_d = {addr_d, (go_hi ? HALF_HI : HALF_LO)};
      io_out_d = go_hi ? wdata_d[31:16] : wdata_d[15:0];
      strobe_d = setup_strobes(wr_d, lane_be);
    end

    if (go_done) begin
      state_d     = DONE;
      mem_ready_d = 1'b1;
      strobe_d    = STROBE_IDLE;
      if (!wr_d) memdata_out_d = rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      rdata_q       <= '0;
      memdata_out_q <= '0;
      wr_q          <= 1'b0;
      be_hi_q       <= 2'b11;
      mem_ready_q   <= 1'b0;
      sram_a_q      <= '0;
      io_out_q      <= '0;
      strobe_q      <= STROBE_IDLE;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      rdata_q       <= rdata_d;
      memdata_out_q <= memdata_out_d;
      wr_q          <= wr_d;
      be_hi_q       <= be_hi_d;
      mem_ready_q   <= mem_ready_d;
      sram_a_q      <= sram_a_d;
      io_out_q      <= io_out_d;
      strobe_q      <= strobe_d;
    end
  end

  assign memdata_out = memdata_out_q;
  assign mem_ready   = mem_ready_q;
  assign sram_a      = sram_a_q;
  assign sram_io_out = io_out_q;
  assign sram_io_oe  = strobe_q.io_oe;
  assign sram_ce_n   = strobe_q.ce_n;
  assign sram_oe_n   = strobe_q.oe_n;
  assign sram_we_n   = strobe_q.we_n;
  assign sram_lb_n   = strobe_q.lb_n;
  assign sram_ub_n   = strobe_q.ub_n;

endmodule

// File: tb/tb_sram_word_ctrl.sv
// tb/tb_sram_word_ctrl.sv - self-checking bench: WAIT_CYCLES=1 and =3 controllers on a shared SRAM model
module tb_sram_word_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        re_v [2];
  logic        we_v [2];
  logic [29:0] addr_v [2];
  logic [31:0] wd_v [2];
`ifdef SRAM_BYTE_LANE_EN
  logic [3:0]  be_v [2];
`endif
  logic [31:0] mdo [2];
  logic        rdy [2];
  logic [17:0] sa [2];
  logic [15:0] sio_out [2];
  logic [15:0] sio_in [2];
  logic        io_oe [2];
  logic        ce_n [2];
  logic        oe_n [2];
  logic        we_n [2];
  logic        lb_n [2];
  logic        ub_n [2];

  logic [15:0] mem [0:1023];

  int tests = 0;
  int fails = 0;
  logic [31:0] sbq [$];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    sram_word_ctrl #(
      .SRAM_AW     (18),
      .WAIT_CYCLES ((g == 0) ? 1 : 3)
    ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .mem_re      (re_v[g]),
      .mem_we      (we_v[g]),
      .memaddr     (addr_v[g]),
      .memdata_in  (wd_v[g]),
`ifdef SRAM_BYTE_LANE_EN
      .mem_be      (be_v[g]),
`endif
      .memdata_out (mdo[g]),
      .mem_ready   (rdy[g]),
      .sram_a      (sa[g]),
      .sram_io_out (sio_out[g]),
      .sram_io_in  (sio_in[g]),
      .sram_io_oe  (io_oe[g]),
      .sram_ce_n   (ce_n[g]),
      .sram_oe_n   (oe_n[g]),
      .sram_we_n   (we_n[g]),
      .sram_lb_n   (lb_n[g]),
      .sram_ub_n   (ub_n[g])
    );
  end

  // Async SRAM model: reads are combinational, a write lands at each edge it is strobed.
  assign sio_in[0] = mem[sa[0][9:0]];
  assign sio_in[1] = mem[sa[1][9:0]];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!ce_n[k] && !we_n[k]) begin
        if (!lb_n[k]) mem[sa[k][9:0]][7:0]  <= sio_out[k][7:0];
        if (!ub_n[k]) mem[sa[k][9:0]][15:8] <= sio_out[k][15:8];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Bus-level monitor: address frozen while we_n is low, never drive the pad during a read.
  logic [17:0] prev_a [2];
  logic        prev_we [2] = '{1'b1, 1'b1};
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!we_n[k] && !prev_we[k]) check("addr_stable_we_low", 32'(sa[k]), 32'(prev_a[k]));
      if (!oe_n[k]) check("no_pad_drive_on_read", 32'(io_oe[k]), 32'd0);
      prev_a[k]  = sa[k];
      prev_we[k] = we_n[k];
    end
  end

  task automatic run_txn(input int k, input logic rd, input logic wr, input logic [29:0] a,
                         input logic [31:0] d, input logic [3:0] be, input logic [31:0] exp);
    int   n, we_low, halves, w, lat_exp;
    logic seen;
    w       = (k == 0) ? 1 : 3;
    halves  = wr ? (int'(|be[1:0]) + int'(|be[3:2])) : 2;
    lat_exp = halves * (w + 1) + 1;
    if (!wr) sbq.push_back(exp);
    re_v[k]   = rd;
    we_v[k]   = wr;
    addr_v[k] = a;
    wd_v[k]   = d;
`ifdef SRAM_BYTE_LANE_EN
    be_v[k]   = be;
`endif
    @(posedge clk); #1;
    n = 0; we_low = 0; seen = 1'b0;
    while (!seen && n < 60) begin
      @(posedge clk); #1;
      n++;
      if (!we_n[k]) we_low++;
      if (rdy[k]) seen = 1'b1;
    end
    re_v[k] = 1'b0;
    we_v[k] = 1'b0;
    check("latency", seen ? 32'(n + 1) : 32'd0, 32'(lat_exp));
    check("we_low_cycles", 32'(we_low), wr ? 32'(halves * w) : 32'd0);
    if (!wr && sbq.size() > 0) begin
      if (seen) check("read_data", mdo[k], sbq.pop_front());
      else void'(sbq.pop_front());
    end
    @(posedge clk); #1;
    check("ready_single_pulse", 32'(rdy[k]), 32'd0);
  endtask

  typedef struct {
    int          k;
    logic        rd;
    logic        wr;
    logic [29:0] a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [9];

  initial begin
    int   n;
    logic seen;

    tbl[0] = '{0, 1'b0, 1'b1, 30'h5,        32'hDEADBEEF, 32'h0};
    tbl[1] = '{0, 1'b1, 1'b0, 30'h5,        32'h0,        32'hDEADBEEF};
    tbl[2] = '{0, 1'b1, 1'b1, 30'h7,        32'h12345678, 32'h0};
    tbl[3] = '{0, 1'b1, 1'b0, 30'h7,        32'h0,        32'h12345678};
    tbl[4] = '{1, 1'b0, 1'b1, 30'h1,        32'hA5A55A5A, 32'h0};
    tbl[5] = '{1, 1'b0, 1'b1, 30'h2,        32'h01020304, 32'h0};
    tbl[6] = '{1, 1'b1, 1'b0, 30'h1,        32'h0,        32'hA5A55A5A};
    tbl[7] = '{1, 1'b1, 1'b0, 30'h2,        32'h0,        32'h01020304};
    tbl[8] = '{0, 1'b1, 1'b0, 30'h20000005, 32'h0,        32'hDEADBEEF};

    for (int k = 0; k < 2; k++) begin
      re_v[k] = 1'b0; we_v[k] = 1'b0; addr_v[k] = '0; wd_v[k] = '0;
`ifdef SRAM_BYTE_LANE_EN
      be_v[k] = 4'hF;
`endif
    end
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      check("reset_strobes", 32'({ce_n[k], oe_n[k], we_n[k], lb_n[k], ub_n[k], io_oe[k], rdy[k]}),
            32'b1111100);
      check("reset_sram_a", 32'(sa[k]), 32'd0);
      check("reset_io_out", 32'(sio_out[k]), 32'd0);
      check("reset_memdata_out", mdo[k], 32'd0);
    end
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      run_txn(tbl[i].k, tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].d, 4'hF, tbl[i].exp);
      if (i == 0) begin
        check("write_lo_half_0x0A", 32'(mem[10]), 32'h0000BEEF);
        check("write_hi_half_0x0B", 32'(mem[11]), 32'h0000DEAD);
      end
    end

`ifdef SRAM_BYTE_LANE_EN
    run_txn(0, 1'b0, 1'b1, 30'h9, 32'h11223344, 4'hF, 32'h0);
    run_txn(0, 1'b0, 1'b1, 30'h9, 32'hAABBCCDD, 4'b0011, 32'h0);
    run_txn(0, 1'b1, 1'b0, 30'h9, 32'h0, 4'h0, 32'h1122CCDD);
`endif

    // Reset in the middle of a read: strobes drop at once and the word is never acknowledged.
    re_v[0] = 1'b1; addr_v[0] = 30'h5;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_reset_in_access", 32'(ce_n[0]), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("midop_reset_strobes", 32'({ce_n[0], oe_n[0], we_n[0], lb_n[0], ub_n[0], io_oe[0], rdy[0]}),
          32'b1111100);
    check("midop_reset_memdata_out", mdo[0], 32'd0);
    re_v[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    n = 0; seen = 1'b0;
    while (n < 15) begin
      @(posedge clk); #1;
      n++;
      if (rdy[0]) seen = 1'b1;
    end
    check("no_ready_after_reset", 32'(seen), 32'd0);
    check("idle_after_reset", 32'(ce_n[0]), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
